// File: rtl/rggen_mux_pipe_pkg.sv
// Shared types and helpers for rggen_mux_pipe: storage states, select-width
// derivation and the one-hot legality check (select vectors up to 64 bits).
package rggen_mux_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    localparam int ONEHOT_MAX = 64;

    function automatic int sel_width(input int entries, input int encoded);
        int w;
        if (encoded != 0) begin
            w = (entries > 1) ? $clog2(entries) : 1;
        end else begin
            w = entries;
        end
        return w;
    endfunction

    function automatic logic is_onehot(input logic [ONEHOT_MAX-1:0] vec);
        return ($countones(vec) == 32'd1);
    endfunction

endpackage

// File: rtl/rggen_mux_pipe_skid.sv
// Two-entry skid buffer: main register drives the output, skid register
// absorbs the one word accepted in the cycle the downstream stalls.
module rggen_mux_pipe_skid
    import rggen_mux_pipe_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_load_in;
    logic          w_load_skid;
    logic          w_skid_to_main;

    assign o_valid    = (r_state != ST_EMPTY);
    assign o_ready    = (r_state != ST_SKID);
    assign o_data     = r_main;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    // Next-state and storage-enable decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_in      = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_in   = 1'b1;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_in   = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_fire) begin
                    // Downstream stalled this cycle: park the new word.
                    w_state_nxt = ST_SKID;
                    w_load_skid = 1'b1;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_SKID: begin
                if (w_out_fire) begin
                    w_state_nxt    = ST_FULL;
                    w_skid_to_main = 1'b1;
                end else begin
                    w_state_nxt = ST_SKID;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_in) begin
                r_main <= i_data;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/rggen_mux_pipe.sv
// Registered one-hot/binary select mux behind a valid/ready skid buffer.
// Define RGGEN_MUX_PIPE_SELECT_CHECK_EN to build the o_select_error logic.
module rggen_mux_pipe
    import rggen_mux_pipe_pkg::*;
#(
    parameter  int WIDTH          = 32,
    parameter  int ENTRIES        = 4,
    parameter  int ENCODED_SELECT = 0,
    localparam int SEL_WIDTH      = sel_width(ENTRIES, ENCODED_SELECT)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [SEL_WIDTH-1:0]     i_select,
    input  logic [ENTRIES*WIDTH-1:0] i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_select_error
);

    logic [WIDTH-1:0] w_sel_data;
`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
    logic             w_sel_err;
`endif

    if (ENTRIES == 1) begin : g_single
        logic w_unused_select;
        assign w_unused_select = ^i_select;
        assign w_sel_data      = i_data[WIDTH-1:0];
`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
        assign w_sel_err       = 1'b0;
`endif
    end else if (ENCODED_SELECT != 0) begin : g_encoded
        // Indices past the last entry match nothing and yield zero.
        always_comb begin
            w_sel_data = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (i_select == SEL_WIDTH'(j)) begin
                    w_sel_data = i_data[j*WIDTH +: WIDTH];
                end else begin
                    w_sel_data = w_sel_data;
                end
            end
        end
`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
        localparam logic [SEL_WIDTH:0] LAST_IDX = (SEL_WIDTH+1)'(ENTRIES - 1);
        assign w_sel_err = ({1'b0, i_select} > LAST_IDX);
`endif
    end else begin : g_onehot
        // AND-OR reduction: multi-hot selects OR their words together.
        always_comb begin
            w_sel_data = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (i_select[j]) begin
                    w_sel_data = w_sel_data | i_data[j*WIDTH +: WIDTH];
                end else begin
                    w_sel_data = w_sel_data;
                end
            end
        end
`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
        assign w_sel_err = ~is_onehot(ONEHOT_MAX'(i_select));
`endif
    end

`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
    localparam int DW = WIDTH + 1;
    logic [DW-1:0] w_in_word;
    logic [DW-1:0] w_out_word;
    assign w_in_word                = {w_sel_err, w_sel_data};
    assign {o_select_error, o_data} = w_out_word;
`else
    localparam int DW = WIDTH;
    logic [DW-1:0] w_in_word;
    logic [DW-1:0] w_out_word;
    assign w_in_word      = w_sel_data;
    assign o_data         = w_out_word;
    assign o_select_error = 1'b0;
`endif

    rggen_mux_pipe_skid #(
        .DW (DW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (w_in_word),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (w_out_word)
    );

endmodule

// File: tb/tb_rggen_mux_pipe.sv
// Bench for rggen_mux_pipe: one-hot (4 entries) and encoded (5 entries) instances
// checked against a queue-based transaction model plus directed vector tables.
module tb_rggen_mux_pipe;

`ifdef RGGEN_MUX_PIPE_SELECT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oh_valid, oh_ready, oh_ovalid, oh_iready, oh_err;
    logic [3:0]  oh_sel;
    logic [63:0] oh_data;
    logic [15:0] oh_odata;
    logic        en_valid, en_ready, en_ovalid, en_iready, en_err;
    logic [2:0]  en_sel;
    logic [79:0] en_data;
    logic [15:0] en_odata;

    always #5 clk = ~clk;

    rggen_mux_pipe #(.WIDTH(16), .ENTRIES(4), .ENCODED_SELECT(0)) u_dut_oh (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(oh_valid), .o_ready(oh_ready),
        .i_select(oh_sel), .i_data(oh_data), .o_valid(oh_ovalid), .i_ready(oh_iready),
        .o_data(oh_odata), .o_select_error(oh_err));

    rggen_mux_pipe #(.WIDTH(16), .ENTRIES(5), .ENCODED_SELECT(1)) u_dut_en (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(en_valid), .o_ready(en_ready),
        .i_select(en_sel), .i_data(en_data), .o_valid(en_ovalid), .i_ready(en_iready),
        .o_data(en_odata), .o_select_error(en_err));

    int checks = 0;
    int errors = 0;

    // Model: each instance is a FIFO of at most two {err,data} words.
    logic [16:0] oh_q[$];
    logic [16:0] en_q[$];
    int          oh_pops = 0;
    bit          oh_acc;

    logic        nx_rst_n, nx_oh_valid, nx_oh_iready, nx_en_valid, nx_en_iready;
    logic [3:0]  nx_oh_sel;
    logic [63:0] nx_oh_data;
    logic [2:0]  nx_en_sel;
    logic [79:0] nx_en_data;

    typedef struct {
        logic [3:0]  oh_sel;
        logic [15:0] oh_exp;
        logic        oh_err;
        logic [2:0]  en_sel;
        logic [15:0] en_exp;
        logic        en_err;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] oh_model(input logic [3:0] s, input logic [63:0] d);
        logic [15:0] r;
        int          hot;
        r   = 16'h0000;
        hot = 0;
        for (int j = 0; j < 4; j++) begin
            if (s[j]) begin
                r   = r | d[j*16 +: 16];
                hot = hot + 1;
            end
        end
        return {ERR_EN && (hot != 1), r};
    endfunction

    function automatic logic [16:0] en_model(input logic [2:0] s, input logic [79:0] d);
        int idx;
        idx = int'(s);
        if (idx < 5) return {1'b0, d[idx*16 +: 16]};
        return {ERR_EN, 16'h0000};
    endfunction

    // One cycle: check outputs against the model at negedge, then apply next inputs.
    task automatic tick();
        int oh_n;
        int en_n;
        @(negedge clk);
        oh_n = oh_q.size();
        en_n = en_q.size();
        chk("oh_o_valid", 32'(oh_ovalid), 32'(oh_n > 0));
        chk("oh_o_ready", 32'(oh_ready), 32'(oh_n < 2));
        chk("en_o_valid", 32'(en_ovalid), 32'(en_n > 0));
        chk("en_o_ready", 32'(en_ready), 32'(en_n < 2));
        if (oh_n > 0) begin
            chk("oh_o_data", 32'(oh_odata), 32'(oh_q[0][15:0]));
            chk("oh_o_err", 32'(oh_err), 32'(oh_q[0][16]));
        end
        if (en_n > 0) begin
            chk("en_o_data", 32'(en_odata), 32'(en_q[0][15:0]));
            chk("en_o_err", 32'(en_err), 32'(en_q[0][16]));
        end
        rst_n     = nx_rst_n;
        oh_valid  = nx_oh_valid;
        oh_sel    = nx_oh_sel;
        oh_data   = nx_oh_data;
        oh_iready = nx_oh_iready;
        en_valid  = nx_en_valid;
        en_sel    = nx_en_sel;
        en_data   = nx_en_data;
        en_iready = nx_en_iready;
        oh_acc    = 1'b0;
        if (rst_n) begin
            if (oh_n > 0 && nx_oh_iready) begin
                void'(oh_q.pop_front());
                oh_pops++;
            end
            if (nx_oh_valid && oh_n < 2) begin
                oh_q.push_back(oh_model(nx_oh_sel, nx_oh_data));
                oh_acc = 1'b1;
            end
            if (en_n > 0 && nx_en_iready) void'(en_q.pop_front());
            if (nx_en_valid && en_n < 2) en_q.push_back(en_model(nx_en_sel, nx_en_data));
        end
    endtask

    initial begin
        logic [63:0] oh_tbl_data;
        logic [79:0] en_tbl_data;
        int          sent;
        int          cyc;
        int          pops0;

        oh_tbl_data = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        en_tbl_data = {16'h0504, 16'h0403, 16'h0302, 16'h0201, 16'h0100};
        tbl[0] = '{4'b0100, 16'h0033, 1'b0, 3'd4, 16'h0504, 1'b0};
        tbl[1] = '{4'b0110, 16'h0033, 1'b1, 3'd6, 16'h0000, 1'b1};
        tbl[2] = '{4'b0000, 16'h0000, 1'b1, 3'd0, 16'h0100, 1'b0};
        tbl[3] = '{4'b1000, 16'h0044, 1'b0, 3'd5, 16'h0000, 1'b1};
        tbl[4] = '{4'b1111, 16'h0077, 1'b1, 3'd2, 16'h0302, 1'b0};
        tbl[5] = '{4'b0001, 16'h0011, 1'b0, 3'd7, 16'h0000, 1'b1};

        rst_n = 1'b0; oh_valid = 1'b1; oh_sel = 4'b0001; oh_data = oh_tbl_data; oh_iready = 1'b1;
        en_valid = 1'b1; en_sel = 3'd0; en_data = en_tbl_data; en_iready = 1'b1;
        nx_rst_n = 1'b0; nx_oh_valid = 1'b1; nx_oh_sel = 4'b0001; nx_oh_data = oh_tbl_data;
        nx_oh_iready = 1'b1; nx_en_valid = 1'b1; nx_en_sel = 3'd0; nx_en_data = en_tbl_data;
        nx_en_iready = 1'b1;

        // Reset held with i_valid high.
        tick(); tick(); tick();
        chk("rst_oh_valid", 32'(oh_ovalid), 32'd0);
        chk("rst_oh_ready", 32'(oh_ready), 32'd1);
        chk("rst_oh_data", 32'(oh_odata), 32'd0);
        chk("rst_oh_err", 32'(oh_err), 32'd0);
        chk("rst_en_valid", 32'(en_ovalid), 32'd0);
        chk("rst_en_data", 32'(en_odata), 32'd0);

        // Release with a word pending: it appears one cycle later.
        nx_rst_n = 1'b1;
        tick();
        nx_oh_valid = 1'b0; nx_en_valid = 1'b0;
        tick();
        chk("first_accept_valid", 32'(oh_ovalid), 32'd1);
        chk("first_accept_data", 32'(oh_odata), 32'h0011);
        chk("first_accept_en", 32'(en_odata), 32'h0100);
        tick();

        // Directed vector table, back to back at full rate.
        nx_oh_data = oh_tbl_data; nx_en_data = en_tbl_data;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                nx_oh_valid = 1'b1; nx_oh_sel = tbl[k].oh_sel;
                nx_en_valid = 1'b1; nx_en_sel = tbl[k].en_sel;
            end else begin
                nx_oh_valid = 1'b0; nx_en_valid = 1'b0;
            end
            tick();
            if (k > 0) begin
                chk("tbl_oh_valid", 32'(oh_ovalid), 32'd1);
                chk("tbl_oh_data", 32'(oh_odata), 32'(tbl[k-1].oh_exp));
                chk("tbl_oh_err", 32'(oh_err), 32'(tbl[k-1].oh_err & ERR_EN));
                chk("tbl_en_data", 32'(en_odata), 32'(tbl[k-1].en_exp));
                chk("tbl_en_err", 32'(en_err), 32'(tbl[k-1].en_err & ERR_EN));
            end
        end
        tick();

        // Eight-word stream with a three-cycle downstream stall.
        sent = 0; cyc = 0; pops0 = oh_pops;
        while ((sent < 8 || oh_q.size() > 0) && cyc < 60) begin
            nx_oh_valid  = (sent < 8);
            nx_oh_sel    = 4'(1 << (sent % 4));
            nx_oh_data   = {$urandom, $urandom};
            nx_oh_iready = !(cyc >= 3 && cyc <= 5);
            tick();
            if (oh_acc) sent++;
            if (cyc == 3) chk("stall_ready_before", 32'(oh_ready), 32'd1);
            if (cyc == 4) chk("stall_ready_after", 32'(oh_ready), 32'd0);
            cyc++;
        end
        chk("stream_budget", 32'(cyc < 60), 32'd1);
        chk("stream_words", 32'(oh_pops - pops0), 32'd8);
        nx_oh_iready = 1'b1;

        // Fill into SKID, then reset asynchronously mid-cycle.
        nx_oh_valid = 1'b1; nx_oh_iready = 1'b0; nx_oh_sel = 4'b0010;
        nx_oh_data = {$urandom, $urandom};
        tick(); tick(); tick();
        chk("skid_entered", 32'(oh_ready), 32'd0);
        #1 rst_n = 1'b0;
        nx_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(oh_ovalid), 32'd0);
        chk("async_rst_ready", 32'(oh_ready), 32'd1);
        chk("async_rst_data", 32'(oh_odata), 32'd0);
        oh_q.delete(); en_q.delete();
        nx_oh_valid = 1'b0; nx_oh_iready = 1'b1;
        tick(); tick();
        nx_rst_n = 1'b1;
        tick(); tick(); tick();

        // Randomized traffic, including illegal selects.
        for (int i = 0; i < 400; i++) begin
            nx_oh_valid  = ($urandom_range(3) != 0);
            nx_oh_iready = ($urandom_range(2) != 0);
            nx_oh_sel    = ($urandom_range(1) != 0) ? 4'(1 << $urandom_range(3)) : 4'($urandom);
            nx_oh_data   = {$urandom, $urandom};
            nx_en_valid  = ($urandom_range(3) != 0);
            nx_en_iready = ($urandom_range(2) != 0);
            nx_en_sel    = 3'($urandom);
            nx_en_data   = 80'({$urandom, $urandom, $urandom});
            tick();
        end
        nx_oh_valid = 1'b0; nx_oh_iready = 1'b1; nx_en_valid = 1'b0; nx_en_iready = 1'b1;
        tick(); tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rggen_mux_pipe.md
# rggen_mux_pipe

Registered, flow-controlled successor to the combinational one-hot AND-OR mux. It selects one of ENTRIES data words per transaction and presents the result one cycle later behind a valid/ready handshake. A two-entry skid buffer sustains full throughput under output backpressure. The block sits between register-read fan-in and the bus response path, where the read mux must be timing-isolated.

## Interface
Parameters:
- WIDTH, 32, data word width (≥1)
- ENTRIES, 4, number of selectable inputs (≥1)
- ENCODED_SELECT, 0, 0 = one-hot select, 1 = binary index select
- localparam SEL_WIDTH = ENCODED_SELECT ? max(1, $clog2(ENTRIES)) : ENTRIES

Ports:
- i_clk  input  1  clock; the single clock domain
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  input transaction present
- o_ready  output  1  block can accept input this cycle
- i_select  input  SEL_WIDTH  one-hot mask or binary index
- i_data  input  ENTRIES×WIDTH  packed candidate words, entry 0 in LSBs
- o_valid  output  1  output transaction present
- i_ready  input  1  downstream accepts output
- o_data  output  WIDTH  selected word
- o_select_error  output  1  sideband, qualified by o_valid: select was illegal

## Operation
- Input handshake fires on i_valid & o_ready. Output handshake fires on o_valid & i_ready.
- Selection is evaluated combinationally on i_select/i_data at input handshake. Result and error are captured into storage.
- One-hot mode: o_data = OR over j of (i_select[j] ? i_data[j] : 0). Zero-hot selects produce 0; multi-hot selects produce the bitwise OR. Error = select not exactly one-hot.
- Encoded mode: o_data = i_data[i_select] if i_select < ENTRIES, else 0 with error=1.
- ENTRIES==1: i_select is ignored, o_data = i_data[0], and error is never set.
- Storage: main register (drives o_data) plus skid register. States:
  - EMPTY: transitions to FULL on input handshake.
  - FULL: no event, or both handshakes → stay (main reloaded on input). Output handshake only → EMPTY. Input handshake only, i_ready low → SKID (capture into skid).
  - SKID: on output handshake, skid moves to main → FULL. Otherwise hold.
- o_valid = (state != EMPTY). o_ready = (state != SKID), decoded from a register.
- Order is strictly preserved. No transaction is dropped or duplicated.

## Timing
- Reset values: o_valid=0, o_ready=1, o_data=0, o_select_error=0, state=EMPTY, skid contents=0.
- Latency: input handshake at edge N → o_valid high after edge N, in cycle N+1.
- Throughput: one transaction per cycle while i_ready stays high.
- o_ready and o_data depend on registers only. No combinational path from i_ready to o_ready or from i_data to o_data.
- Simultaneous input and output handshake in FULL: the new word replaces main. o_valid stays high.
- i_ready deasserted mid-stream: at most one extra word is absorbed. o_ready drops the following cycle.
- Reset mid-operation: all storage is cleared immediately (asynchronous) and in-flight transactions are discarded.
- o_data and o_select_error stay stable while o_valid & !i_ready.

## Configuration
- Macro RGGEN_MUX_PIPE_SELECT_CHECK_EN.
- Defined: the error logic is built and o_select_error behaves as specified.
- Undefined: the error logic and error storage bits are omitted, and o_select_error is tied to 0. Data behaviour is identical in both cases, including 0 for an out-of-range index.

## Structure
- Package rggen_mux_pipe_pkg contains:
  - typedef enum state (EMPTY, FULL, SKID)
  - function for SEL_WIDTH
  - function for the one-hot legality check (popcount==1)
- Sub-module rggen_mux_pipe_skid: generic {WIDTH+1}-bit two-entry skid buffer with the state machine above. The top level holds only the select decode and the AND-OR reduction.

## Test plan
- Reset with i_valid=1 asserted → o_valid=0, o_ready=1, o_data=0. After release, first accept yields o_valid in the next cycle.
- One-hot, ENTRIES=4, data {0x44,0x33,0x22,0x11}, select 4'b0100, i_ready=1 → o_data=0x33, error=0, one cycle later.
- Select 4'b0110 → o_data=0x33|0x22=0x33, error=1. Select 4'b0000 → o_data=0, error=1. With the macro undefined → same data, error=0.
- Encoded, ENTRIES=5, index 3'd6 → o_data=0, error=1. Index 3'd4 → i_data[4].
- Stream of 8 words with i_ready held low 3 cycles mid-stream → o_ready low exactly one cycle after the stall and all 8 words arrive in order with no duplicates.
- Assert i_rst_n low while in SKID → o_valid=0 and o_ready=1 immediately, with no stale word emitted after release.
